gibbs_scheduler: RTL and testbench
==================================

Name: gibbs_scheduler

Overview:
- Sequences block-Gibbs sampling over a ROWS x COLS grid of Boltzmann nodes using a two-colour checkerboard, so no node updates in the same cycle as any of its 4 neighbours.
- Runs a programmable number of burn-in sweeps, then collects num_samples snapshots of the grid, keeping one snapshot every thin sweeps.
- Emits each snapshot over a valid/ready handshake.
- Sits above the node array: drives each node's update enable and reads back every node output.

Parameters:
- ROWS, 2: grid rows.
- COLS, 2: grid columns.
- SETTLE, 2: cycles per colour phase (minimum 1). Allows the sigmoid/noise path to settle before the next phase.
- N, ROWS*COLS: derived node count. Not overridable.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: launch a run. Sampled only in IDLE.
- abort, input, 1: terminate the run and return to IDLE.
- burn_in, input, 16: number of burn-in sweeps. Latched on start.
- num_samples, input, 16: number of snapshots to emit. Latched on start.
- thin, input, 8: sweeps between snapshots. 0 is treated as 1. Latched on start.
- node_state, input, N: current node outputs. Index i = r*COLS + c.
- upd_en, output, N: per-node update enable, one-cycle pulses.
- sample_data, output, N: snapshot payload.
- sample_valid, output, 1: snapshot available.
- sample_ready, input, 1: consumer accepts the snapshot.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle pulse at normal completion.

Behaviour:
- Reset: synchronous, active-high. While rst is high, next edge forces state=IDLE and clears all counters. Outputs upd_en, sample_data, sample_valid, busy, done all read 0. Reset mid-run discards the run.
- Colour: colour(i) = (r+c) mod 2. Phase 0 drives the colour-0 mask; phase 1 drives the colour-1 mask.
- Phase timing:
  - A phase lasts SETTLE cycles.
  - upd_en = that phase's colour mask in the first cycle of the phase, 0 for the remaining SETTLE-1 cycles.
  - One sweep = phase 0 then phase 1 = 2*SETTLE cycles.
- States: IDLE, BURN, SAMPLE, CAPTURE, EMIT, DONE.
- IDLE:
  - start=1 latches burn_in, num_samples and thin_eff = max(thin,1).
  - Next state is BURN if burn_in>0; else SAMPLE if num_samples>0; else DONE.
  - First upd_en pulse appears in the first cycle after the start cycle.
- BURN:
  - Runs burn_in sweeps back to back.
  - After the last sweep cycle, goes to SAMPLE, or to DONE if num_samples=0.
- SAMPLE:
  - Runs thin_eff sweeps back to back, then goes to CAPTURE.
- CAPTURE:
  - One cycle. upd_en=0. Registers sample_data <= node_state.
  - The extra cycle guarantees SETTLE=1 updates have landed before capture.
- EMIT:
  - sample_valid=1. sample_data is held stable and upd_en=0 until sample_ready=1.
  - On the handshake cycle (valid & ready): sample count decrements.
  - If samples remain, next state is SAMPLE with sample_valid=0 the next cycle; if the count reaches 0, next state is DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - start is accepted again in the cycle after DONE.
- busy: 1 in BURN, SAMPLE, CAPTURE and EMIT; 0 in IDLE and DONE.
- start is ignored whenever the state is not IDLE. Inputs are latched, so changes to burn_in, num_samples or thin mid-run have no effect.
- abort:
  - From any non-IDLE state, next state is IDLE with all outputs 0 and no done pulse.
  - If abort coincides with a handshake in EMIT, abort wins; the sample is considered consumed by the consumer, but no further samples are produced.
- Precedence: rst > abort > all else. abort and start in the same IDLE cycle: abort wins, start is ignored.
- Counters:
  - Sweep counters are 16-bit; thin counter is 8-bit; phase counter is ceil(log2(SETTLE+1)) bits.
  - None wrap: counters are loaded at state entry and count down to terminal values.

Test Plan:
- ROWS=COLS=2, SETTLE=2, burn_in=1, num_samples=0, start at cycle 0 -> upd_en = 1001, 0000, 0110, 0000 in cycles 1-4; done=1 and busy=0 at cycle 5; no sample_valid.
- burn_in=0, num_samples=2, thin=1, node_state=4'hA, sample_ready tied high -> one sweep (4 cycles), CAPTURE, then sample_valid=1 with data 4'hA for one cycle; repeated once; exactly 2 handshakes, then a single done pulse.
- Same run with sample_ready low for 5 cycles during EMIT while node_state changes to 4'h5 -> sample_valid stays 1, sample_data stays 4'hA, upd_en=0 throughout; handshake completes when ready rises.
- thin=0 vs thin=3, num_samples=1, burn_in=0 -> 4 vs 12 upd cycles before the CAPTURE cycle; upd_en patterns repeat per sweep.
- rst asserted during burn-in sweep 3 of burn_in=10 -> next cycle all outputs 0; a fresh start runs the full 10 burn-in sweeps.
- abort during EMIT -> IDLE next cycle, no done pulse. start pulsed while busy -> ignored, run length unchanged. abort and start in the same IDLE cycle -> stays IDLE.

Source files
------------

// File: rtl/gibbs_scheduler.sv
// gibbs_scheduler: checkerboard block-Gibbs sequencer for a ROWS x COLS grid
// of Boltzmann nodes. It runs burn-in sweeps, then captures and emits thinned
// snapshots of the node outputs over a valid/ready handshake.
//
// Handshake (sample_valid / sample_ready): sample_valid is high only while the
// FSM sits in EMIT. sample_data is stable for as long as sample_valid is high.
// A transfer happens on any rising edge where sample_valid & sample_ready are
// both 1. sample_valid never depends combinationally on sample_ready.
module gibbs_scheduler #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int SETTLE = 2,
  localparam int N     = ROWS * COLS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   burn_in,
  input  logic [15:0]   num_samples,
  input  logic [7:0]    thin,
  input  logic [N-1:0]  node_state,
  output logic [N-1:0]  upd_en,
  output logic [N-1:0]  sample_data,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  localparam int PW = $clog2(SETTLE + 1);
  localparam logic [PW-1:0] PH_FIRST = PW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BURN    = 3'd1,
    S_SAMPLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;     // cycles left in the current phase, minus one
  logic          colour_q, colour_d;   // colour being updated in this phase
  logic [15:0]   sweep_q, sweep_d;     // burn-in sweeps left, including the current one
  logic [7:0]    thin_cnt_q, thin_cnt_d; // sampling sweeps left before a capture
  logic [7:0]    thin_eff_q, thin_eff_d;
  logic [15:0]   samp_q, samp_d;       // snapshots still to be emitted
  logic [N-1:0]  data_q, data_d;

  logic [N-1:0]  mask0, mask1;
  logic          phase_end;
  logic          sweep_end;
  logic [7:0]    thin_eff_in;

  // Checkerboard colour masks: node (r,c) belongs to colour (r+c) mod 2.
  always_comb begin
    mask0 = '0;
    mask1 = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (((r + c) % 2) == 0) mask0[r*COLS+c] = 1'b1;
        else                    mask1[r*COLS+c] = 1'b1;
      end
    end
  end

  // Next-state and counter logic; abort overrides everything except reset.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    colour_d   = colour_q;
    sweep_d    = sweep_q;
    thin_cnt_d = thin_cnt_q;
    thin_eff_d = thin_eff_q;
    samp_d     = samp_q;
    data_d     = data_q;

    thin_eff_in = (thin == 8'd0) ? 8'd1 : thin;
    phase_end   = (phase_q == '0);
    sweep_end   = phase_end && colour_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          thin_eff_d = thin_eff_in;
          thin_cnt_d = thin_eff_in;
          samp_d     = num_samples;
          sweep_d    = burn_in;
          phase_d    = PH_FIRST;
          colour_d   = 1'b0;
          if (burn_in != 16'd0)          state_d = S_BURN;
          else if (num_samples != 16'd0) state_d = S_SAMPLE;
          else                           state_d = S_DONE;
        end
      end
      S_BURN, S_SAMPLE: begin
        // Phase counter wraps into the other colour at the end of each phase;
        // after colour 1 this lands back on colour 0 for the next sweep.
        if (!phase_end) begin
          phase_d = phase_q - 1'b1;
        end else begin
          phase_d  = PH_FIRST;
          colour_d = ~colour_q;
        end
        if (sweep_end) begin
          if (state_q == S_BURN) begin
            if (sweep_q == 16'd1) begin
              thin_cnt_d = thin_eff_q;
              state_d    = (samp_q == 16'd0) ? S_DONE : S_SAMPLE;
            end else begin
              sweep_d = sweep_q - 16'd1;
            end
          end else begin
            if (thin_cnt_q == 8'd1) state_d = S_CAPTURE;
            else                    thin_cnt_d = thin_cnt_q - 8'd1;
          end
        end
      end
      S_CAPTURE: begin
        data_d  = node_state;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (sample_ready) begin
          samp_d = samp_q - 16'd1;
          if (samp_q == 16'd1) begin
            state_d = S_DONE;
          end else begin
            thin_cnt_d = thin_eff_q;
            phase_d    = PH_FIRST;
            colour_d   = 1'b0;
            state_d    = S_SAMPLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      phase_d    = '0;
      colour_d   = 1'b0;
      sweep_d    = '0;
      thin_cnt_d = '0;
      thin_eff_d = '0;
      samp_d     = '0;
      data_d     = '0;
    end
  end

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      colour_q   <= 1'b0;
      sweep_q    <= '0;
      thin_cnt_q <= '0;
      thin_eff_q <= '0;
      samp_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      colour_q   <= colour_d;
      sweep_q    <= sweep_d;
      thin_cnt_q <= thin_cnt_d;
      thin_eff_q <= thin_eff_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
    end
  end

  // Moore outputs: update pulse only in the first cycle of each phase.
  always_comb begin
    upd_en       = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    busy         = 1'b0;
    done         = 1'b0;
    dbg_state    = state_q;
    case (state_q)
      S_BURN, S_SAMPLE: begin
        busy = 1'b1;
        if (phase_q == PH_FIRST) upd_en = colour_q ? mask1 : mask0;
      end
      S_CAPTURE: busy = 1'b1;
      S_EMIT: begin
        busy         = 1'b1;
        sample_valid = 1'b1;
        sample_data  = data_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gibbs_scheduler.sv
// tb_gibbs_scheduler: builds an expected cycle-by-cycle trace of every output
// from the sweep/sample rules, drives the inputs recorded in that trace, and
// compares the DUT outputs each cycle.
module tb_gibbs_scheduler;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int SETTLE = 2;
  localparam int N      = ROWS * COLS;
  localparam int OW     = 3 * N + 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   burn_in = '0;
  logic [15:0]   num_samples = '0;
  logic [7:0]    thin = '0;
  logic [N-1:0]  node_state = '0;
  logic [N-1:0]  upd_en;
  logic [N-1:0]  sample_data;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  gibbs_scheduler #(.ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .burn_in(burn_in), .num_samples(num_samples), .thin(thin),
    .node_state(node_state), .upd_en(upd_en), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // one cycle of the expected trace: inputs to drive plus outputs expected
  typedef struct packed {
    logic         start;
    logic         abort;
    logic         rst;
    logic         ready;
    logic [N-1:0] node;
    logic [N-1:0] upd;
    logic         valid;
    logic [N-1:0] data;
    logic         busy;
    logic         done;
  } ent_t;

  ent_t tr[$];
  int total = 0;
  int bad = 0;
  logic [15:0] cfg_burn;
  logic [15:0] cfg_ns;
  logic [7:0]  cfg_thin;

  // scoreboard comparison
  task automatic check(input logic [OW-1:0] act, input logic [OW-1:0] exp,
                       input string tag, input int cyc);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] colour_mask(input int col);
    logic [N-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (((r + c) % 2) == col) m[r*COLS+c] = 1'b1;
    return m;
  endfunction

  function automatic ent_t mk(input logic [N-1:0] upd, input logic valid,
                              input logic [N-1:0] data, input logic bsy,
                              input logic dn, input logic rdy);
    ent_t e;
    e.start = bsy ? 1'($urandom_range(0, 1)) : 1'b0;
    e.abort = 1'b0;
    e.rst   = 1'b0;
    e.ready = rdy;
    e.node  = N'($urandom);
    e.upd   = upd;
    e.valid = valid;
    e.data  = data;
    e.busy  = bsy;
    e.done  = dn;
    return e;
  endfunction

  task automatic push_sweep();
    for (int col = 0; col < 2; col++) begin
      tr.push_back(mk(colour_mask(col), 1'b0, '0, 1'b1, 1'b0, 1'($urandom_range(0, 1))));
      for (int k = 1; k < SETTLE; k++)
        tr.push_back(mk('0, 1'b0, '0, 1'b1, 1'b0, 1'($urandom_range(0, 1))));
    end
  endtask

  // reference model: expected trace of a whole run from the start cycle
  task automatic build_run(input int burn, input int ns, input int th,
                           input int stall_lo, input int stall_hi);
    ent_t e;
    int te;
    int k;
    logic [N-1:0] cap;
    tr.delete();
    cfg_burn = 16'(burn);
    cfg_ns   = 16'(ns);
    cfg_thin = 8'(th);
    te = (th == 0) ? 1 : th;
    e = mk('0, 1'b0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    e.start = 1'b1;
    tr.push_back(e);
    for (int b = 0; b < burn; b++) push_sweep();
    for (int s = 0; s < ns; s++) begin
      for (int t = 0; t < te; t++) push_sweep();
      tr.push_back(mk('0, 1'b0, '0, 1'b1, 1'b0, 1'($urandom_range(0, 1))));
      cap = tr[tr.size()-1].node;
      k = $urandom_range(stall_lo, stall_hi);
      for (int j = 0; j < k; j++) tr.push_back(mk('0, 1'b1, cap, 1'b1, 1'b0, 1'b0));
      tr.push_back(mk('0, 1'b1, cap, 1'b1, 1'b0, 1'b1));
    end
    tr.push_back(mk('0, 1'b0, '0, 1'b0, 1'b1, 1'($urandom_range(0, 1))));
    tr.push_back(mk('0, 1'b0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1))));
  endtask

  // truncate the run with abort or reset at entry idx; idle follows
  task automatic cut(input int idx, input bit use_rst);
    ent_t e;
    while (tr.size() > idx + 1) void'(tr.pop_back());
    e = tr[idx];
    if (use_rst) e.rst = 1'b1;
    else         e.abort = 1'b1;
    tr[idx] = e;
    tr.push_back(mk('0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    tr.push_back(mk('0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
  endtask

  // driver: check the current cycle, then apply that cycle's inputs
  task automatic run_trace(input string tag);
    ent_t e;
    for (int i = 0; i < tr.size(); i++) begin
      e = tr[i];
      check({upd_en, sample_valid, sample_data, busy, done},
            {e.upd, e.valid, e.data, e.busy, e.done}, tag, i);
      start        = e.start;
      abort        = e.abort;
      rst          = e.rst;
      sample_ready = e.ready;
      node_state   = e.node;
      if (i == 0) begin
        burn_in     = cfg_burn;
        num_samples = cfg_ns;
        thin        = cfg_thin;
      end else begin
        burn_in     = 16'($urandom);
        num_samples = 16'($urandom);
        thin        = 8'($urandom);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    sample_ready = 1'b0;
  endtask

  int idx;

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({upd_en, sample_valid, sample_data, busy, done}, '0, "reset_held", 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check({upd_en, sample_valid, sample_data, busy, done}, '0, "reset_rel", 0);

    // burn-in only: 1001,0000,0110,0000 then done
    build_run(1, 0, 1, 0, 0);
    run_trace("burn_only");

    // two samples, ready without stalls
    build_run(0, 2, 1, 0, 0);
    run_trace("two_samples");

    // two samples with 5-cycle stalls while node_state changes
    build_run(0, 2, 1, 5, 5);
    run_trace("stall5");

    // thin=0 behaves as thin=1; thin=3 gives three sweeps per capture
    build_run(0, 1, 0, 0, 0);
    run_trace("thin0");
    build_run(0, 1, 3, 0, 1);
    run_trace("thin3");

    // reset during burn-in sweep 3 of 10, then a full fresh run
    build_run(10, 1, 1, 0, 0);
    cut(10, 1'b1);
    run_trace("rst_mid");
    build_run(10, 1, 1, 0, 2);
    run_trace("after_rst");

    // abort during an EMIT stall
    build_run(1, 3, 2, 2, 4);
    idx = 0;
    while (!tr[idx].valid) idx++;
    cut(idx + 1, 1'b0);
    run_trace("abort_emit");

    // abort coinciding with a handshake
    build_run(0, 2, 1, 0, 0);
    idx = 0;
    while (!tr[idx].valid) idx++;
    cut(idx, 1'b0);
    run_trace("abort_hs");

    // abort and start together in IDLE: start ignored
    build_run(2, 1, 1, 0, 0);
    cut(0, 1'b0);
    run_trace("abort_start");

    // randomized runs, some cut short by abort or reset
    for (int n = 0; n < 10; n++) begin
      build_run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), 0, 3);
      if ($urandom_range(0, 2) == 0 && tr.size() > 4)
        cut($urandom_range(1, tr.size() - 3), 1'($urandom_range(0, 1)));
      run_trace("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
